// File: rtl/program_loader.sv
// Run-time loader for the 16-word instruction store: it takes an 8-bit byte stream and serves the fetch port.
// Build option: define PROGRAM_LOADER_CHECKSUM_EN to add a trailing XOR checksum byte and a sticky load_error.
module program_loader #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [WORD_WIDTH-1:0] instruction,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_HI   = 3'd2;
    localparam logic [2:0] S_LO   = 3'd3;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK  = 3'd4;
`endif
    localparam logic [2:0] S_FILL = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(DEPTH);

    logic [2:0]            state, state_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nxt;
    logic [CNT_W-1:0]      n_words, n_words_nxt;
    logic [CNT_W-1:0]      count_nxt;
    logic [7:0]            hi_byte, hi_byte_nxt;
    logic                  hold_nxt, done_nxt, ready_nxt;
    logic                  accept;
    logic [CNT_W-1:0]      len_raw, len_dec;
    logic                  mem_we;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic [WORD_WIDTH-1:0] mem [DEPTH];

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] csum, csum_nxt;
    logic       err_q, err_nxt;
`endif

    assign accept  = byte_valid && byte_ready;
    assign len_raw = byte_in[CNT_W-1:0];
    // Zero or oversize length means a full program.
    assign len_dec = (len_raw == '0 || len_raw > FULL_CNT) ? FULL_CNT : len_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            n_words      <= FULL_CNT;
            words_loaded <= '0;
            hi_byte      <= '0;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            byte_ready   <= 1'b0;
        end else begin
            state        <= state_nxt;
            wr_ptr       <= wr_ptr_nxt;
            n_words      <= n_words_nxt;
            words_loaded <= count_nxt;
            hi_byte      <= hi_byte_nxt;
            cpu_hold     <= hold_nxt;
            load_done    <= done_nxt;
            byte_ready   <= ready_nxt;
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum  <= '0;
            err_q <= 1'b0;
        end else begin
            csum  <= csum_nxt;
            err_q <= err_nxt;
        end
    end
    assign load_error = err_q;
`else
    assign load_error = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        wr_ptr_nxt  = wr_ptr;
        n_words_nxt = n_words;
        count_nxt   = words_loaded;
        hi_byte_nxt = hi_byte;
        hold_nxt    = cpu_hold;
        mem_we      = 1'b0;
        mem_wdata   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_nxt    = csum;
        err_nxt     = err_q;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt  = S_LEN;
                    wr_ptr_nxt = '0;
                    count_nxt  = '0;
                    hold_nxt   = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_nxt   = '0;
                    err_nxt    = 1'b0;
`endif
                end
            end
            S_LEN: begin
                if (accept) begin
                    n_words_nxt = len_dec;
                    state_nxt   = S_HI;
                end
            end
            S_HI: begin
                if (accept) begin
                    hi_byte_nxt = byte_in;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_nxt    = csum ^ byte_in;
`endif
                    state_nxt   = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    mem_we    = 1'b1;
                    mem_wdata = WORD_WIDTH'({hi_byte, byte_in});
                    count_nxt = words_loaded + 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_nxt  = csum ^ byte_in;
`endif
                    // Pointer saturates at the top so a full load never wraps.
                    if (wr_ptr != LAST_ADDR) begin
                        wr_ptr_nxt = wr_ptr + 1'b1;
                    end
                    if (count_nxt == n_words) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_nxt = S_CHK;
`else
                        state_nxt = (n_words < FULL_CNT) ? S_FILL : S_DONE;
`endif
                    end else begin
                        state_nxt = S_HI;
                    end
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    if (byte_in != csum) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = (n_words < FULL_CNT) ? S_FILL : S_DONE;
                    end
                end
            end
`endif
            S_FILL: begin
                mem_we    = 1'b1;
                mem_wdata = '0;
                if (wr_ptr == LAST_ADDR) begin
                    state_nxt = S_DONE;
                end else begin
                    wr_ptr_nxt = wr_ptr + 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Registered outputs follow the state being entered.
        done_nxt  = (state_nxt == S_DONE);
        if (state_nxt == S_DONE) begin
            hold_nxt = 1'b0;
        end
        ready_nxt = (state_nxt == S_LEN) || (state_nxt == S_HI) || (state_nxt == S_LO)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                 || (state_nxt == S_CHK)
`endif
                 ;
    end

    // Instruction store is intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= mem_wdata;
        end
    end

    assign instruction = mem[address];

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader with a word-level reference model of the instruction store.
module tb_program_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [3:0]  address;
    logic [15:0] instruction;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [4:0]  words_loaded;

    int n_vec;
    int n_err;

    logic [15:0] wq [$];
    logic [15:0] ref_mem [16];

    program_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .address      (address),
        .instruction  (instruction),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sweep_mem();
        for (int a = 0; a < 16; a++) begin
            address = 4'(a);
            #1;
            check($sformatf("mem[%0d]", a), 32'(instruction), 32'(ref_mem[a]));
        end
    endtask

    // mode 0: valid held high, 1: valid toggles every cycle, 2: random stalls plus stray start pulses
    task automatic apply_load(input logic [7:0] lbyte, input int mode, input int abort_words, input bit bad_csum);
        int          n;
        logic [7:0]  q [$];
        logic [7:0]  x;
        int          abort_at;
        int          idx;
        int          cyc;
        int          done_cyc;
        int          done_cnt;
        int          tail;
        bit          acc;
        bit          bad;
        bit          aborted;
        bit          ok;
        int          exp_lat;

        n = int'(lbyte[4:0]);
        if (n == 0 || n > 16) n = 16;
        q.delete();
        q.push_back(lbyte);
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            q.push_back(wq[i][15:8]);
            q.push_back(wq[i][7:0]);
            x = x ^ wq[i][15:8] ^ wq[i][7:0];
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        bad = bad_csum && (x != 8'hFF);
        q.push_back(bad_csum ? 8'hFF : x);
        exp_lat = n + 18;
`else
        bad = 1'b0;
        exp_lat = n + 17;
`endif
        abort_at = (abort_words >= 0) ? 1 + 2 * abort_words : -1;
        aborted  = 1'b0;

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("hold_after_start", 32'(cpu_hold), 32'd1);

        idx = 0; cyc = 0; done_cyc = -1; done_cnt = 0; tail = 0;
        while (cyc < 400 && tail < 20) begin
            if (idx == abort_at) begin
                rst = 1'b1;
                byte_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            case (mode)
                0:       byte_valid = (idx < q.size());
                1:       byte_valid = (idx < q.size()) && (cyc % 2 == 0);
                default: byte_valid = (idx < q.size()) && ($urandom_range(0, 2) != 0);
            endcase
            byte_in = (idx < q.size()) ? q[idx] : 8'h00;
            start   = (mode == 2) && (idx < q.size()) && ($urandom_range(0, 3) == 0);
            acc = byte_valid && byte_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) idx++;
            if (load_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                check("hold_at_done", 32'(cpu_hold), 32'd0);
            end
            if (idx == q.size()) tail++;
        end
        start = 1'b0;
        byte_valid = 1'b0;
        check("cycle_budget", 32'(cyc >= 400), 32'd0);

        ok = !aborted && !bad;
        check("done_pulses", 32'(done_cnt), ok ? 32'd1 : 32'd0);
        if (ok && mode == 0) check("done_latency", 32'(done_cyc), 32'(exp_lat));
        check("load_error", 32'(load_error), 32'(bad));
        check("cpu_hold_idle", 32'(cpu_hold), ok ? 32'd0 : 32'd1);
        check("byte_ready_idle", 32'(byte_ready), 32'd0);
        check("words_loaded", 32'(words_loaded), aborted ? 32'd0 : 32'(n));

        if (aborted) begin
            for (int i = 0; i < abort_words; i++) ref_mem[i] = wq[i];
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (i < n) ref_mem[i] = wq[i];
                else if (ok) ref_mem[i] = 16'h0000;
            end
        end
        sweep_mem();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        start = 1'b0;
        byte_in = 8'h00;
        byte_valid = 1'b0;
        address = 4'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_error", 32'(load_error), 32'd0);
        check("rst_words_loaded", 32'(words_loaded), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reference five-word program
        wq = '{16'hA601, 16'hB401, 16'h3681, 16'hF400, 16'h8200};
        apply_load(8'h05, 0, -1, 1'b0);

        // Length byte zero means sixteen words, no fill
        wq.delete();
        for (int i = 0; i < 16; i++) wq.push_back(16'h1E06);
        apply_load(8'h00, 0, -1, 1'b0);

        // Valid toggling on a two-word load
        wq = '{16'h1234, 16'hABCD};
        apply_load(8'h02, 1, -1, 1'b0);

        // Reset after three words of a five-word load, then a fresh two-word load
        wq = '{16'h5A5A, 16'h6B6B, 16'h7C7C, 16'h8D8D, 16'h9E9E};
        apply_load(8'h05, 0, 3, 1'b0);
        wq = '{16'hC0DE, 16'hBEEF};
        apply_load(8'h02, 0, -1, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        wq = '{16'hA601, 16'hB401, 16'h3681, 16'hF400, 16'h8200};
        apply_load(8'h05, 0, -1, 1'b1);
`endif

        // Random programs, lengths (including out-of-range codes) and stall patterns
        for (int t = 0; t < 10; t++) begin
            logic [7:0] lb;
            lb = 8'($urandom);
            wq.delete();
            for (int i = 0; i < 16; i++) wq.push_back(16'($urandom));
            apply_load(lb, int'($urandom_range(0, 2)), -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
